abc_sequence_driver: RTL and testbench
======================================

// Module: abc_sequence_driver
// PURPOSE
//  Transmit-side counterpart of the a ##1 b ##1 c sequence checker.
//  On a start handshake, drives a, b, c on consecutive posedges of clk, repeated rep_count times.
//  Optional idle gaps separate repetitions; done pulses at the end.
//  Replaces hand-written initial-block stimulus feeding sequence/event tests.
// PARAMETERS
//  CNT_W       8  width of rep_count and seq_count
//  GAP_CYCLES  1  all-zero cycles between repetitions (0 = back-to-back)
//  HOLD        1  1: a, b stay high until c phase ends (cumulative); 0: one-hot pulses
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  start_valid  in   1      request a transaction
//  start_ready  out  1      high iff state==IDLE (combinational from state reg only)
//  rep_count    in   CNT_W  repetitions; sampled on accept
//  abort        in   1      synchronous cancel; effective only when busy
//  a            out  1      sequence phase 1
//  b            out  1      sequence phase 2
//  c            out  1      sequence phase 3
//  busy         out  1      state != IDLE
//  done         out  1      1-cycle pulse after the last repetition
//  seq_count    out  CNT_W  repetitions completed in current/last transaction
// BEHAVIOUR
//  Reset: state=IDLE; a=b=c=done=busy=0; seq_count=0; start_ready=1.
//  Accept: start_valid && start_ready at edge N -> remaining=rep_count, seq_count=0.
//  Outputs: Moore, decoded from the state register. No input->output combinational path.
//  FSM states: IDLE, PH_A, PH_B, PH_C, GAP.
//   IDLE -> PH_A on accept with rep_count!=0.
//   IDLE, rep_count==0: stays IDLE; done=1 in cycle N+1; a/b/c never assert.
//   PH_A: a=1.
//   PH_B: b=1; a=HOLD.
//   PH_C: c=1; a=b=HOLD.
//   PH_C exit: remaining--, seq_count++.
//    remaining becomes 0: -> IDLE, done=1 for one cycle.
//    else GAP_CYCLES==0: -> PH_A.
//    else: -> GAP.
//   GAP: a=b=c=0 for exactly GAP_CYCLES cycles, then -> PH_A.
//  Latency: a high in cycle N+1, b in N+2, c in N+3.
//   Back-to-back period is 3+GAP_CYCLES cycles.
//   done is in cycle N+1+rep_count*(3+GAP_CYCLES)-GAP_CYCLES.
//  Protocol guarantee: every repetition satisfies @(posedge clk) a ##1 b ##1 c.
//   With HOLD=0 the phases are strictly one-hot.
//  Abort while busy: next state IDLE; a=b=c=0; no done pulse; seq_count holds its value.
//  Abort in IDLE: ignored. abort && start_valid in IDLE: start accepted.
//  Abort in PH_C: takes precedence; that repetition is not counted.
//  rst mid-transaction: immediate return to reset values; the sampled count is discarded.
//  seq_count never exceeds rep_count, so it cannot wrap.
//   It holds after done until the next accept.
//  start_valid while busy: not accepted (ready=0); the requester must hold valid.
// STRUCTURE
//  Package abc_seq_pkg: typedef enum logic [2:0] seq_state_t {IDLE,PH_A,PH_B,PH_C,GAP};
//   localparams for phase encodings.
//  Sub-module abc_gap_timer:
//   loadable down-counter of width $clog2(GAP_CYCLES+1).
//   Ports: load, expire. Omitted (generate) when GAP_CYCLES==0.
//  Top: FSM, remaining/seq_count registers, output decode.
// TESTING
//  1. rst, GAP=1, HOLD=1, start rep_count=2:
//     a,b,c = 100,110,111,000,100,110,111,000.
//     done pulses in cycle N+8; seq_count=2.
//  2. HOLD=0, GAP=0, rep_count=3:
//     one-hot 100,010,001 x3 back-to-back; done pulses in cycle N+10.
//     The sequence checker fires 3 times.
//  3. rep_count=0: no a/b/c activity; done in cycle N+1; seq_count=0; start_ready stays 1.
//  4. rep_count=5, abort in PH_B of repetition 2:
//     next cycle all outputs 0, busy=0, no done, seq_count=1.
//  5. rst asserted in PH_C, then released:
//     all outputs 0 and seq_count=0; a fresh start with rep_count=1 completes normally.
//  6. start_valid held during an active transaction:
//     not accepted until IDLE; accepted on the first IDLE cycle; new rep_count is sampled there.

Source files
------------

// File: rtl/abc_seq_pkg.sv
// Shared types for the a/b/c sequence driver.
// State encoding plus the a/b/c phase decode.
package abc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH_A = 3'd1,
        PH_B = 3'd2,
        PH_C = 3'd3,
        GAP  = 3'd4
    } seq_state_t;

    localparam logic [2:0] ABC_OFF = 3'b000;
    localparam logic [2:0] ABC_A   = 3'b100;
    localparam logic [2:0] ABC_B   = 3'b010;
    localparam logic [2:0] ABC_C   = 3'b001;

    // hold=1 keeps earlier phases asserted (cumulative a, ab, abc)
    function automatic logic [2:0] abc_decode(seq_state_t s, logic hold);
        logic [2:0] v;
        v = ABC_OFF;
        unique case (s)
            PH_A: v = ABC_A;
            PH_B: v = ABC_B | (hold ? ABC_A : ABC_OFF);
            PH_C: v = ABC_C | (hold ? (ABC_A | ABC_B) : ABC_OFF);
            default: v = ABC_OFF;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/abc_gap_timer.sv
// Loadable down-counter timing the idle gap between repetitions.
// expire is high in the last gap cycle.
module abc_gap_timer
    import abc_seq_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int W = $clog2(GAP_CYCLES + 1);
    localparam logic [W-1:0] LOAD_V = W'(GAP_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_V;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/abc_sequence_driver.sv
// Drives a ##1 b ##1 c rep_count times per start handshake.
// Moore outputs; optional idle gap between repetitions.
module abc_sequence_driver
    import abc_seq_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 1,
    parameter int HOLD       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] rep_count,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] seq_count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic HOLD_B = (HOLD != 0);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             gap_load;
    logic             gap_expire;

    if (GAP_CYCLES > 0) begin : g_gap
        abc_gap_timer #(
            .GAP_CYCLES(GAP_CYCLES)
        ) u_gap (
            .clk   (clk),
            .rst   (rst),
            .load  (gap_load),
            .expire(gap_expire)
        );
    end else begin : g_nogap
        logic unused_gap_load;
        assign unused_gap_load = gap_load;
        assign gap_expire = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        gap_load = 1'b0;
        // abort wins over every busy transition, including the PH_C count
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        rem_d = rep_count;
                        cnt_d = '0;
                        if (rep_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = PH_A;
                        end
                    end
                end
                PH_A: state_d = PH_B;
                PH_B: state_d = PH_C;
                PH_C: begin
                    rem_d = rem_q - ONE;
                    cnt_d = cnt_q + ONE;
                    if (rem_q == ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = PH_A;
                    end else begin
                        state_d  = GAP;
                        gap_load = 1'b1;
                    end
                end
                GAP: begin
                    if (gap_expire) begin
                        state_d = PH_A;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign {a, b, c}   = abc_decode(state_q, HOLD_B);
    assign busy        = (state_q != IDLE);
    assign start_ready = (state_q == IDLE);
    assign done        = done_q;
    assign seq_count   = cnt_q;

endmodule

// File: tb/tb_abc_sequence_driver.sv
// Bench for abc_sequence_driver: two configurations, one reference
// model computing outputs from the elapsed cycle count of a transaction.
module tb_abc_sequence_driver;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sv;
    logic          ab;
    logic [CW-1:0] rc;

    logic [1:0]    sr_w, a_w, b_w, c_w, busy_w, done_w;
    logic [CW-1:0] sq_w [2];

    int tests = 0;
    int fails = 0;

    // instance 0: GAP=1 HOLD=1, instance 1: GAP=0 HOLD=0
    int gap_p  [2] = '{1, 0};
    int hold_p [2] = '{1, 0};

    bit run_m  [2];
    bit done_m [2];
    int t_m    [2];
    int rep_m  [2];
    int seq_m  [2];

    always #5 clk = ~clk;

    abc_sequence_driver #(.CNT_W(CW), .GAP_CYCLES(1), .HOLD(1)) u0 (
        .clk        (clk),
        .rst        (rst),
        .start_valid(sv),
        .start_ready(sr_w[0]),
        .rep_count  (rc),
        .abort      (ab),
        .a          (a_w[0]),
        .b          (b_w[0]),
        .c          (c_w[0]),
        .busy       (busy_w[0]),
        .done       (done_w[0]),
        .seq_count  (sq_w[0])
    );

    abc_sequence_driver #(.CNT_W(CW), .GAP_CYCLES(0), .HOLD(0)) u1 (
        .clk        (clk),
        .rst        (rst),
        .start_valid(sv),
        .start_ready(sr_w[1]),
        .rep_count  (rc),
        .abort      (ab),
        .a          (a_w[1]),
        .b          (b_w[1]),
        .c          (c_w[1]),
        .busy       (busy_w[1]),
        .done       (done_w[1]),
        .seq_count  (sq_w[1])
    );

    // t_m = cycles since accept (1 = first a cycle); transaction spans
    // rep*(3+gap)-gap cycles, done follows in the next cycle
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int p;
            int len;
            int nt;
            p = 3 + gap_p[i];
            if (rst) begin
                run_m[i]  <= 1'b0;
                done_m[i] <= 1'b0;
                t_m[i]    <= 0;
                seq_m[i]  <= 0;
            end else if (run_m[i]) begin
                if (ab) begin
                    run_m[i]  <= 1'b0;
                    done_m[i] <= 1'b0;
                end else begin
                    nt  = t_m[i] + 1;
                    len = rep_m[i] * p - gap_p[i];
                    t_m[i] <= nt;
                    if (nt > len) begin
                        run_m[i]  <= 1'b0;
                        done_m[i] <= 1'b1;
                        seq_m[i]  <= rep_m[i];
                    end else begin
                        seq_m[i] <= (nt - 1 + gap_p[i]) / p;
                    end
                end
            end else begin
                done_m[i] <= 1'b0;
                if (sv) begin
                    seq_m[i] <= 0;
                    if (rc == '0) begin
                        done_m[i] <= 1'b1;
                    end else begin
                        run_m[i] <= 1'b1;
                        t_m[i]   <= 1;
                        rep_m[i] <= int'(rc);
                    end
                end
            end
        end
    end

    task automatic chk(string tag, logic [CW-1:0] obs, logic [CW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int k;
            bit ea, eb, ec;
            ea = 0; eb = 0; ec = 0;
            if (run_m[i]) begin
                k  = (t_m[i] - 1) % (3 + gap_p[i]);
                ea = (k == 0) || (hold_p[i] != 0 && (k == 1 || k == 2));
                eb = (k == 1) || (hold_p[i] != 0 && k == 2);
                ec = (k == 2);
            end
            chk($sformatf("u%0d a", i), CW'(a_w[i]), CW'(ea));
            chk($sformatf("u%0d b", i), CW'(b_w[i]), CW'(eb));
            chk($sformatf("u%0d c", i), CW'(c_w[i]), CW'(ec));
            chk($sformatf("u%0d busy", i), CW'(busy_w[i]), CW'(run_m[i]));
            chk($sformatf("u%0d ready", i), CW'(sr_w[i]), CW'(!run_m[i]));
            chk($sformatf("u%0d done", i), CW'(done_w[i]), CW'(done_m[i]));
            chk($sformatf("u%0d seq_count", i), sq_w[i], CW'(seq_m[i]));
        end
    endtask

    task automatic step(bit s, int r, bit abt, bit rs);
        @(negedge clk);
        check_all();
        sv  = s;
        rc  = CW'(r);
        ab  = abt;
        rst = rs;
    endtask

    task automatic idle(int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        sv  = 1'b0;
        ab  = 1'b0;
        rc  = '0;
        @(posedge clk);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        // two repetitions, then three
        step(1, 2, 0, 0);
        idle(12);
        step(1, 3, 0, 0);
        idle(14);
        // zero repetitions: immediate done
        step(1, 0, 0, 0);
        idle(3);
        // abort in repetition 2 (u0 in PH_B, u1 in PH_C)
        step(1, 5, 0, 0);
        idle(5);
        step(0, 0, 1, 0);
        idle(4);
        // reset mid-transaction, then a fresh single repetition
        step(1, 3, 0, 0);
        idle(2);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        idle(6);
        // abort together with start while idle: start wins
        step(1, 1, 1, 0);
        idle(5);
        // start held while busy; new count sampled on first idle cycle
        step(1, 2, 0, 0);
        for (int j = 0; j < 14; j++) step(1, 1, 0, 0);
        idle(10);
        // randomized traffic
        for (int j = 0; j < 400; j++) begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 4),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 63) == 0);
        end
        idle(25);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
